// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: input handshake plus registered result flags.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_cmd;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             shiftcarry_in;
  logic             out_valid;
  logic [WIDTH-1:0] rslt;
  logic [WIDTH-1:0] rslt_hi;
  logic             shiftcarry_out;
  logic             zero;
  logic             cmd_err;

  modport master (
    output in_valid, alu_cmd, inA, inB, shiftcarry_in,
    input  in_ready, out_valid, rslt, rslt_hi, shiftcarry_out, zero, cmd_err
  );

  modport slave (
    input  in_valid, alu_cmd, inA, inB, shiftcarry_in,
    output in_ready, out_valid, rslt, rslt_hi, shiftcarry_out, zero, cmd_err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: logic/arith ops in one EXEC cycle, shift-add MUL and
// N-bit shifts iterate one step per BUSY cycle; result registers update on completion.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_BUSY = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] C_AND = 4'd0, C_XOR = 4'd1, C_OR = 4'd2, C_LSL = 4'd3,
                         C_LSR = 4'd4, C_ADD = 4'd5, C_SUB = 4'd6, C_PASS = 4'd7,
                         C_MUL = 4'd8, C_SHLN = 4'd10, C_SHRN = 4'd11;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cmd;
  logic [WIDTH-1:0] r_a, r_lo, r_hi;
  logic             r_cin;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rslt, r_rslt_hi;
  logic             r_cout, r_zero, r_err, r_ovld;

  logic             w_accept, w_iter, w_last, w_done, w_ready;
  logic [CW-1:0]    w_n;
  logic [WIDTH-1:0] w_shl, w_shr, w_res;
  logic             w_c, w_err;
  logic [WIDTH:0]   w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0] w_fin_lo, w_fin_hi;
  logic             w_fin_c, w_fin_err;

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_n        = CW'(r_lo[SHW-1:0]);
  assign w_iter     = (r_cmd == C_MUL) || (((r_cmd == C_SHLN) || (r_cmd == C_SHRN)) && (w_n != '0));
  assign w_last     = (r_cnt == CW'(1));
  assign w_done     = ((r_state == S_EXEC) && !w_iter) || ((r_state == S_BUSY) && w_last);
  assign w_shl      = {r_a[WIDTH-2:0], r_cin};
  assign w_shr      = {r_cin, r_a[WIDTH-1:1]};
  // Shift-add step: r_lo starts as B and is consumed LSB-first while the product fills in from the top.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};

  // Single-cycle results, evaluated in EXEC
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_err = 1'b0;
    case (r_cmd)
      C_AND:  w_res = r_a & r_lo;
      C_XOR:  w_res = r_a ^ r_lo;
      C_OR:   w_res = r_a | r_lo;
      C_LSL:  begin w_res = w_shl; w_c = r_a[WIDTH-1]; end
      C_LSR:  begin w_res = w_shr; w_c = r_a[0]; end
      C_ADD:  {w_c, w_res} = {1'b0, r_a} + {1'b0, r_lo};
      C_SUB:  {w_c, w_res} = {1'b0, r_a} + {1'b0, ~r_lo} + {{WIDTH{1'b0}}, 1'b1};
      C_PASS: w_res = r_a;
      C_MUL:  w_res = '0;
      C_SHLN, C_SHRN: w_res = r_a;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = w_iter ? S_BUSY : S_IDLE;
      S_BUSY:  if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready   = (r_state == S_IDLE);
    w_fin_lo  = w_res;
    w_fin_hi  = '0;
    w_fin_c   = w_c;
    w_fin_err = w_err;
    if (r_state == S_BUSY) begin
      w_fin_err = 1'b0;
      case (r_cmd)
        C_MUL:   begin {w_fin_hi, w_fin_lo} = w_mul_next; w_fin_c = 1'b0; end
        C_SHLN:  begin w_fin_lo = w_shl; w_fin_c = r_a[WIDTH-1]; end
        C_SHRN:  begin w_fin_lo = w_shr; w_fin_c = r_a[0]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_a       <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_cin     <= 1'b0;
      r_cnt     <= '0;
      r_rslt    <= '0;
      r_rslt_hi <= '0;
      r_cout    <= 1'b0;
      r_zero    <= 1'b0;
      r_err     <= 1'b0;
      r_ovld    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd <= bus.alu_cmd;
        r_a   <= bus.inA;
        r_lo  <= bus.inB;
        r_cin <= bus.shiftcarry_in;
      end else if (r_state == S_EXEC) begin
        r_hi  <= '0;
        r_cnt <= (r_cmd == C_MUL) ? CW'(WIDTH) : w_n;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
        case (r_cmd)
          C_MUL:   {r_hi, r_lo} <= w_mul_next;
          C_SHLN:  r_a <= w_shl;
          C_SHRN:  r_a <= w_shr;
          default: ;
        endcase
      end
      r_ovld <= w_done;
      if (w_done) begin
        r_rslt    <= w_fin_lo;
        r_rslt_hi <= w_fin_hi;
        r_cout    <= w_fin_c;
        r_err     <= w_fin_err;
        r_zero    <= ({w_fin_hi, w_fin_lo} == '0);
      end
    end
  end

  assign bus.in_ready       = w_ready;
  assign bus.out_valid      = r_ovld;
  assign bus.rslt           = r_rslt;
  assign bus.rslt_hi        = r_rslt_hi;
  assign bus.shiftcarry_out = r_cout;
  assign bus.zero           = r_zero;
  assign bus.cmd_err        = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16; latency is counted in edges after the accepting edge.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(8))  b8();
  alu_seq_if #(.WIDTH(16)) b16();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                      input logic c, output int lat);
    int n;
    n = 0;
    while (!b8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    b8.alu_cmd = cmd; b8.inA = a; b8.inB = b; b8.shiftcarry_in = c; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (b8.out_valid) begin lat = k; break; end
    end
  endtask

  task automatic run16(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                       input logic c, output int lat);
    int n;
    n = 0;
    while (!b16.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    b16.alu_cmd = cmd; b16.inA = a; b16.inB = b; b16.shiftcarry_in = c; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (b16.out_valid) begin lat = k; break; end
    end
  endtask

  // Expected results for cmds 0-7 with A=0xAA, B=0x55, cin=0
  logic [7:0] exp_r [8] = '{8'h00, 8'hFF, 8'hFF, 8'h54, 8'h55, 8'hFF, 8'h55, 8'hAA};
  logic       exp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       exp_z [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int lat;
    int rdy_low;
    int ov_cnt;
    logic [7:0] held;
    b8.in_valid = 1'b0;  b8.alu_cmd = '0;  b8.inA = '0;  b8.inB = '0;  b8.shiftcarry_in = 1'b0;
    b16.in_valid = 1'b0; b16.alu_cmd = '0; b16.inA = '0; b16.inB = '0; b16.shiftcarry_in = 1'b0;

    #12;
    chk("rst_in_ready",  b8.in_ready, 1);
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_rslt",      b8.rslt, 0);
    chk("rst_rslt_hi",   b8.rslt_hi, 0);
    chk("rst_cout",      b8.shiftcarry_out, 0);
    chk("rst_zero",      b8.zero, 0);
    chk("rst_cmd_err",   b8.cmd_err, 0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(4'(i), 8'hAA, 8'h55, 1'b0, lat);
      chk($sformatf("op%0d_lat", i),  lat, 1);
      chk($sformatf("op%0d_rslt", i), b8.rslt, exp_r[i]);
      chk($sformatf("op%0d_cout", i), b8.shiftcarry_out, exp_c[i]);
      chk($sformatf("op%0d_zero", i), b8.zero, exp_z[i]);
      chk($sformatf("op%0d_hi", i),   b8.rslt_hi, 0);
      chk($sformatf("op%0d_err", i),  b8.cmd_err, 0);
      held = b8.rslt;
      @(posedge clk); #1;
      chk($sformatf("op%0d_pulse", i), b8.out_valid, 0);
      chk($sformatf("op%0d_hold", i),  b8.rslt, held);
    end

    // MUL with in_valid held high throughout BUSY carrying a different command
    b8.alu_cmd = 4'd8; b8.inA = 8'hAA; b8.inB = 8'h55; b8.shiftcarry_in = 1'b0; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.alu_cmd = 4'd0; b8.inA = 8'h00; b8.inB = 8'h00;
    lat = -1; rdy_low = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!b8.in_ready) rdy_low++;
      @(posedge clk); #1;
      if (b8.out_valid) begin lat = k; break; end
    end
    b8.in_valid = 1'b0;
    chk("mul_lat",      lat, 9);
    chk("mul_rdy_low",  rdy_low, 9);
    chk("mul_rslt",     b8.rslt, 8'h72);
    chk("mul_hi",       b8.rslt_hi, 8'h38);
    chk("mul_cout",     b8.shiftcarry_out, 0);
    chk("mul_zero",     b8.zero, 0);
    @(posedge clk); #1;
    chk("mul_pulse",    b8.out_valid, 0);

    run8(4'd10, 8'h81, 8'h03, 1'b1, lat);
    chk("shl3_lat",  lat, 4);
    chk("shl3_rslt", b8.rslt, 8'h0F);
    chk("shl3_cout", b8.shiftcarry_out, 0);
    chk("shl3_hi",   b8.rslt_hi, 0);

    run8(4'd11, 8'h81, 8'h00, 1'b1, lat);
    chk("shr0_lat",  lat, 1);
    chk("shr0_rslt", b8.rslt, 8'h81);
    chk("shr0_cout", b8.shiftcarry_out, 0);

    run8(4'd11, 8'h81, 8'h02, 1'b1, lat);
    chk("shr2_lat",  lat, 3);
    chk("shr2_rslt", b8.rslt, 8'hE0);
    chk("shr2_cout", b8.shiftcarry_out, 0);

    run8(4'd13, 8'hFF, 8'h01, 1'b0, lat);
    chk("rsv_lat",  lat, 1);
    chk("rsv_rslt", b8.rslt, 0);
    chk("rsv_hi",   b8.rslt_hi, 0);
    chk("rsv_err",  b8.cmd_err, 1);
    chk("rsv_zero", b8.zero, 1);
    chk("rsv_cout", b8.shiftcarry_out, 0);

    run8(4'd5, 8'h10, 8'h20, 1'b0, lat);
    chk("add_rslt", b8.rslt, 8'h30);
    chk("add_err",  b8.cmd_err, 0);
    chk("add_zero", b8.zero, 0);

    // Abort a MUL with reset mid-BUSY
    b8.alu_cmd = 4'd8; b8.inA = 8'hFF; b8.inB = 8'hFF; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rslt",     b8.rslt, 0);
    chk("abort_ready",    b8.in_ready, 1);
    chk("abort_out_vld",  b8.out_valid, 0);
    chk("abort_hi",       b8.rslt_hi, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (b8.out_valid) ov_cnt++;
    end
    chk("abort_no_ovld", ov_cnt, 0);

    run8(4'd5, 8'h01, 8'hFF, 1'b0, lat);
    chk("post_add_lat",  lat, 1);
    chk("post_add_rslt", b8.rslt, 0);
    chk("post_add_cout", b8.shiftcarry_out, 1);
    chk("post_add_zero", b8.zero, 1);

    run16(4'd8, 16'hFFFF, 16'hFFFF, 1'b0, lat);
    chk("mul16_lat",  lat, 17);
    chk("mul16_rslt", b16.rslt, 16'h0001);
    chk("mul16_hi",   b16.rslt_hi, 16'hFFFE);
    chk("mul16_zero", b16.zero, 0);
    @(posedge clk); #1;
    chk("mul16_pulse", b16.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
